// File: rtl/parity_serial_checker.sv
// rtl/parity_serial_checker.sv - framed serial parity checker with optional failed-frame counter
//
// A start pulse opens a frame; WIDTH data bits arrive LSB first on din (qualified by
// din_vld), followed by one parity bit. The assembled word, parity bit and pass/fail
// result are registered together with a one-cycle done strobe.
//
// Parameters:
//   WIDTH   data bits per frame (>= 1)
//   ODD     1 = odd parity (pass when ones over data+parity is odd), 0 = even parity
//
// Ports:
//   clk      clock, rising edge
//   rst_n    asynchronous active-low reset
//   start    frame start request, accepted only when idle
//   din      serial bit
//   din_vld  din is valid this cycle
//   clr_cnt  synchronous clear of err_cnt (wins over a simultaneous increment)
//   i        last received data word, bit 0 = first bit received
//   p        last received parity bit
//   pc       parity result of last frame, 1 = pass
//   done     one-cycle strobe, frame result valid
//   busy     frame in progress
//   err_cnt  saturating count of failed frames
//
// Build option: define PARITY_ERR_CNT_EN to build the 8-bit err_cnt counter;
// otherwise err_cnt is tied to 0 and clr_cnt is ignored.

module parity_serial_checker #(
    parameter int WIDTH = 4,
    parameter int ODD   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             din,
    input  logic             din_vld,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] i,
    output logic             p,
    output logic             pc,
    output logic             done,
    output logic             busy,
    output logic [7:0]       err_cnt
);

    localparam int            CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);
    localparam logic          ODD_B = (ODD != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    bitcnt;
    logic [WIDTH-1:0] shadow;
    logic             run_par;
    logic             take_bit;
    logic             take_par;
    logic             pass;

    assign take_bit = (state == DATA) && din_vld;
    assign take_par = (state == PAR) && din_vld;
    // Total ones parity over data and parity bit, compared against the configured sense.
    assign pass     = ((run_par ^ din) == ODD_B);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = DATA;
            DATA: if (din_vld && (bitcnt == LAST)) state_nxt = PAR;
            PAR:  if (din_vld) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state != IDLE);
    end

    // Datapath: shift-in, running parity and the registered frame result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitcnt  <= '0;
            shadow  <= '0;
            run_par <= 1'b0;
            i       <= '0;
            p       <= 1'b0;
            pc      <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if ((state == IDLE) && start) begin
                bitcnt  <= '0;
                run_par <= 1'b0;
            end
            if (take_bit) begin
                shadow[bitcnt] <= din;
                run_par        <= run_par ^ din;
                bitcnt         <= bitcnt + 1'b1;
            end
            if (take_par) begin
                i    <= shadow;
                p    <= din;
                pc   <= pass;
                done <= 1'b1;
            end
        end
    end

`ifdef PARITY_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'd0;
        end else if (clr_cnt) begin
            err_cnt <= 8'd0;
        end else if (take_par && !pass && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    logic unused_clr_cnt;
    assign unused_clr_cnt = clr_cnt;
    assign err_cnt        = 8'd0;
`endif

endmodule

// File: tb/tb_parity_serial_checker.sv
// tb/tb_parity_serial_checker.sv - self-checking bench for parity_serial_checker (ODD=1 and ODD=0 instances)

module tb_parity_serial_checker;

    localparam int W = 4;
`ifdef PARITY_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         din = 1'b0;
    logic         din_vld = 1'b0;
    logic         clr_cnt = 1'b0;

    logic [W-1:0] i1, i0;
    logic         p1, p0, pc1, pc0, done1, done0, busy1, busy0;
    logic [7:0]   cnt1, cnt0;

    parity_serial_checker #(.WIDTH(W), .ODD(1)) u_odd (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din), .din_vld(din_vld),
        .clr_cnt(clr_cnt), .i(i1), .p(p1), .pc(pc1), .done(done1), .busy(busy1),
        .err_cnt(cnt1)
    );

    parity_serial_checker #(.WIDTH(W), .ODD(0)) u_even (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din), .din_vld(din_vld),
        .clr_cnt(clr_cnt), .i(i0), .p(p0), .pc(pc0), .done(done0), .busy(busy0),
        .err_cnt(cnt0)
    );

    always #5 clk = ~clk;

    int nerr = 0;
    int nchk = 0;

    // Reference model: frame contents collected as a queue of bits; the result is
    // the population count of the whole frame once WIDTH+1 valid bits have arrived.
    bit           m_active;
    bit           q[$];
    logic [W-1:0] e_i;
    logic         e_p, e_pc1, e_pc0, e_done;
    int           e_cnt1, e_cnt0;

    typedef struct {
        logic [W-1:0] data;
        bit           par;
        int           gap;
        bit           pc1;
        bit           pc0;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        q.delete();
        e_i = '0; e_p = 1'b0; e_pc1 = 1'b0; e_pc0 = 1'b0; e_done = 1'b0;
        e_cnt1 = 0; e_cnt0 = 0;
    endtask

    task automatic model_update(input bit s, input bit d, input bit v, input bit c);
        int ones;
        e_done = 1'b0;
        if (!m_active) begin
            if (s) begin
                m_active = 1'b1;
                q.delete();
            end
        end else if (v) begin
            q.push_back(d);
            if (q.size() == W + 1) begin
                ones = 0;
                foreach (q[k]) ones += int'(q[k]);
                for (int k = 0; k < W; k++) e_i[k] = q[k];
                e_p    = d;
                e_pc1  = (ones % 2 == 1);
                e_pc0  = (ones % 2 == 0);
                e_done = 1'b1;
                m_active = 1'b0;
                if (CNT_EN && !e_pc1 && e_cnt1 < 255) e_cnt1++;
                if (CNT_EN && !e_pc0 && e_cnt0 < 255) e_cnt0++;
            end
        end
        if (c) begin
            e_cnt1 = 0;
            e_cnt0 = 0;
        end
    endtask

    task automatic check_all();
        chk("done_odd", done1, e_done);
        chk("done_even", done0, e_done);
        chk("busy_odd", busy1, m_active);
        chk("busy_even", busy0, m_active);
        chk("i_odd", i1, e_i);
        chk("i_even", i0, e_i);
        chk("p_odd", p1, e_p);
        chk("p_even", p0, e_p);
        chk("pc_odd", pc1, e_pc1);
        chk("pc_even", pc0, e_pc0);
        chk("cnt_odd", cnt1, e_cnt1);
        chk("cnt_even", cnt0, e_cnt0);
    endtask

    // Called just after a falling edge; drives, clocks, then checks on the next falling edge.
    task automatic step(input bit s, input bit d, input bit v, input bit c);
        start = s; din = d; din_vld = v; clr_cnt = c;
        @(posedge clk);
        model_update(s, d, v, c);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1;
        rst_n = 1'b1;
    endtask

    // Start step carries din_vld=1 to confirm it is not taken as a data bit.
    task automatic send_frame(input logic [W-1:0] data, input bit par, input int gap,
                              input bit clr_par, input bit stray, output int lat);
        int n;
        n = 0;
        lat = -1;
        step(1'b1, 1'b1, 1'b1, 1'b0); n++;
        for (int k = 0; k < W; k++) begin
            repeat (gap) begin step(stray, 1'($urandom_range(0, 1)), 1'b0, 1'b0); n++; end
            step(1'b0, data[k], 1'b1, 1'b0); n++;
        end
        repeat (gap) begin step(stray, 1'($urandom_range(0, 1)), 1'b0, 1'b0); n++; end
        step(1'b0, par, 1'b1, clr_par); n++;
        if (done1 === 1'b1) lat = n;
    endtask

    initial begin
        int lat;
        int nb;

        tbl[0] = '{4'b0010, 1'b0, 0, 1'b1, 1'b0};
        tbl[1] = '{4'b0011, 1'b1, 0, 1'b1, 1'b0};
        tbl[2] = '{4'b0111, 1'b1, 0, 1'b0, 1'b1};
        tbl[3] = '{4'b1111, 1'b0, 0, 1'b0, 1'b1};
        tbl[4] = '{4'b1111, 1'b0, 3, 1'b0, 1'b1};
        tbl[5] = '{4'b1000, 1'b0, 1, 1'b1, 1'b0};

        model_reset();
        @(negedge clk);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Table frames, back-to-back (each start lands in the previous done cycle)
        for (int t = 0; t < 6; t++) begin
            send_frame(tbl[t].data, tbl[t].par, tbl[t].gap, 1'b0, 1'b0, lat);
            chk("tbl_pc_odd", pc1, tbl[t].pc1);
            chk("tbl_pc_even", pc0, tbl[t].pc0);
            chk("tbl_i", i1, tbl[t].data);
            chk("tbl_latency", lat, 6 + 5 * tbl[t].gap);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-frame after two data bits, then a fresh frame
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        do_reset();
        chk("rst_busy", busy1, 1'b0);
        chk("rst_i", i1, 4'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(4'b1000, 1'b0, 0, 1'b0, 1'b0, lat);
        chk("after_rst_pc", pc1, 1'b1);
        chk("after_rst_i", i1, 4'b1000);

        // din_vld pulses while idle must not produce done
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            chk("idle_no_done", done1, 1'b0);
        end

        // Stray start during DATA is ignored
        send_frame(4'b0101, 1'b1, 1, 1'b0, 1'b1, lat);
        chk("stray_lat", lat, 11);
        chk("stray_pc", pc1, 1'b1);
        chk("stray_i", i1, 4'b0101);

        // Saturation: 260 failing frames for the odd instance
        for (int f = 0; f < 260; f++) send_frame(4'b0000, 1'b0, 0, 1'b0, 1'b0, lat);
        chk("sat_cnt", cnt1, CNT_EN ? 32'd255 : 32'd0);
        chk("sat_cnt_even", cnt0, 32'd0);

        // Clear coincident with a failing done
        send_frame(4'b0000, 1'b0, 0, 1'b1, 1'b0, lat);
        chk("clr_prio", cnt1, 32'd0);
        chk("clr_pc", pc1, 1'b0);

        // Randomized frames with gaps, stray starts, clears, idle traffic and aborts
        for (int f = 0; f < 300; f++) begin
            repeat ($urandom_range(0, 2))
                step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 19) == 0) begin
                step(1'b1, 1'b0, 1'b0, 1'b0);
                nb = $urandom_range(0, W);
                for (int k = 0; k < nb; k++) step(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
                do_reset();
            end else begin
                send_frame(4'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                           ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), lat);
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
